// File: rtl/mul_fp32_seq.sv
// Multi-cycle IEEE-754 binary32 multiplier: radix-2 shift-add mantissa loop,
// then a normalize stage and a round/pack stage; fixed latency for all operands.
module mul_fp32_seq #(
  parameter int unsigned LATENCY = 27
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [2:0]  rm,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  output logic        busy,
  output logic        valid_out,
  output logic [31:0] product,
  output logic        nv,
  output logic        of,
  output logic        uf,
  output logic        nx
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ITER  = 3'd1;
  localparam logic [2:0] NORM  = 3'd2;
  localparam logic [2:0] ROUND = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [2:0] RM_RTE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  // ITER, NORM and ROUND plus the DONE pulse make up the whole latency.
  localparam logic [4:0] ITER_LAST = 5'(LATENCY - 4);

  logic [2:0]         state;
  logic [4:0]         cnt;
  logic               sign;
  logic signed [9:0]  ea, eb, e_n;
  logic [23:0]        ma, mb, mant_n;
  logic [47:0]        acc;
  logic [2:0]         rm_q;
  logic               sp_inv, sp_nan, sp_inf, sp_zero;
  logic               g_n, s_n;

  logic [7:0]  xa, xb;
  logic [22:0] fa, fb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;

  assign xa = multiplicand[30:23];
  assign xb = multiplier[30:23];
  assign fa = multiplicand[22:0];
  assign fb = multiplier[22:0];

  assign a_zero = (xa == '0) && (fa == '0);
  assign b_zero = (xb == '0) && (fb == '0);
  assign a_inf  = (xa == '1) && (fa == '0);
  assign b_inf  = (xb == '1) && (fb == '0);
  assign a_nan  = (xa == '1) && (fa != '0);
  assign b_nan  = (xb == '1) && (fb != '0);
  assign a_snan = a_nan && !fa[22];
  assign b_snan = b_nan && !fb[22];

  function automatic logic signed [9:0] unbias(input logic [7:0] x);
    return (x == '0) ? -10'sd126 : $signed({2'b00, x}) - 10'sd127;
  endfunction

  logic [24:0] psum;
  assign psum = {1'b0, acc[47:24]} + (mb[0] ? {1'b0, ma} : 25'd0);

  logic [5:0]        lzc, sh;
  logic signed [9:0] e_raw, e_under;
  logic [47:0]       m_norm, m_sh;
  logic              lost;

  always_comb begin
    lzc = 6'd48;
    for (int unsigned i = 0; i < 48; i++)
      if (acc[i]) lzc = 6'(47 - i);
  end

  assign e_raw   = ea + eb + 10'sd1 - $signed({4'b0000, lzc});
  assign e_under = -10'sd126 - e_raw;
  assign m_norm  = acc << lzc;

  // Results below the normal range are denormalized here; the shift saturates
  // once every product bit has already fallen into the sticky bit.
  always_comb begin
    sh = '0;
    if (e_raw < -10'sd126) sh = (e_under > 10'sd50) ? 6'd50 : e_under[5:0];
  end

  assign m_sh = m_norm >> sh;
  assign lost = (m_sh << sh) != m_norm;

  logic              inc, inexact, ovf, tiny, sat_max;
  logic [24:0]       rsum;
  logic [23:0]       mant_r;
  logic signed [9:0] e_r, biased;
  logic [31:0]       res;
  logic [3:0]        res_flags;

  always_comb begin
    case (rm_q)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign && (g_n || s_n);
      RM_RUP:  inc = !sign && (g_n || s_n);
      RM_RMM:  inc = g_n;
      default: inc = g_n && (s_n || mant_n[0]);
    endcase
  end

  assign rsum    = {1'b0, mant_n} + {24'd0, inc};
  assign mant_r  = rsum[24] ? rsum[24:1] : rsum[23:0];
  assign e_r     = rsum[24] ? e_n + 10'sd1 : e_n;
  assign biased  = e_r + 10'sd127;
  assign inexact = g_n | s_n;
  assign tiny    = !mant_r[23];
  assign ovf     = !tiny && (biased >= 10'sd255);
  assign sat_max = (rm_q == RM_RTZ) || ((rm_q == RM_RDN) && !sign) ||
                   ((rm_q == RM_RUP) && sign);

  always_comb begin
    res       = {sign, (tiny ? 8'h00 : biased[7:0]), mant_r[22:0]};
    res_flags = {1'b0, ovf, tiny && inexact, inexact || ovf};
    if (ovf) res = sat_max ? {sign, 8'hFE, 23'h7FFFFF} : {sign, 8'hFF, 23'h000000};
    if (sp_inv) begin
      res       = 32'h7FC00000;
      res_flags = 4'b1000;
    end else if (sp_nan) begin
      res       = 32'h7FC00000;
      res_flags = 4'b0000;
    end else if (sp_inf) begin
      res       = {sign, 8'hFF, 23'h000000};
      res_flags = 4'b0000;
    end else if (sp_zero) begin
      res       = {sign, 31'h0};
      res_flags = 4'b0000;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      product <= '0;
      nv      <= 1'b0;
      of      <= 1'b0;
      uf      <= 1'b0;
      nx      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (valid_in) begin
          sign    <= multiplicand[31] ^ multiplier[31];
          ea      <= unbias(xa);
          eb      <= unbias(xb);
          ma      <= {xa != '0, fa};
          mb      <= {xb != '0, fb};
          rm_q    <= (rm > RM_RMM) ? RM_RTE : rm;
          sp_inv  <= a_snan | b_snan | (a_inf & b_zero) | (a_zero & b_inf);
          sp_nan  <= a_nan | b_nan;
          sp_inf  <= a_inf | b_inf;
          sp_zero <= a_zero | b_zero;
          acc     <= '0;
          cnt     <= '0;
          state   <= ITER;
        end
        ITER: begin
          acc <= {psum, acc[23:1]};
          mb  <= mb >> 1;
          cnt <= cnt + 5'd1;
          if (cnt == ITER_LAST) state <= NORM;
        end
        NORM: begin
          mant_n <= m_sh[47:24];
          g_n    <= m_sh[23];
          s_n    <= (|m_sh[22:0]) | lost;
          e_n    <= (e_raw < -10'sd126) ? -10'sd126 : e_raw;
          state  <= ROUND;
        end
        ROUND: begin
          product           <= res;
          {nv, of, uf, nx}  <= res_flags;
          state             <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state == ITER) || (state == NORM) || (state == ROUND);
  assign valid_out = (state == DONE);

endmodule

// File: tb/tb_mul_fp32_seq.sv
// Scoreboard bench for mul_fp32_seq: directed and random operands checked
// against an exact-arithmetic binary32 rounding model.
module tb_mul_fp32_seq;

  logic        clock;
  logic        reset;
  logic        valid_in;
  logic [2:0]  rm;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        valid_out;
  logic [31:0] product;
  logic        nv, of, uf, nx;

  mul_fp32_seq #(.LATENCY(27)) dut (
    .clock(clock), .reset(reset), .valid_in(valid_in), .rm(rm),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy), .valid_out(valid_out), .product(product),
    .nv(nv), .of(of), .uf(uf), .nx(nx)
  );

  typedef struct {
    int          acc_edge;
    logic [31:0] prod;
    logic [3:0]  flg;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   busy_err = 0;
  logic run = 1'b0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Exact product p*2^e rounded to the nearest binary32 quantum; returns {nv,of,uf,nx,result}.
  function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] r);
    logic s, an, bn, asn, bsn, ai, bi, az, bz, inexact, up, tie, above;
    int ea, eb, e, qe, d, msb, biased;
    longint unsigned ma, mb, p, n, rem, half;
    logic [2:0] mode;
    s   = a[31] ^ b[31];
    an  = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
    bn  = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
    asn = an && !a[22];
    bsn = bn && !b[22];
    ai  = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
    bi  = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
    az  = (a[30:0] == 31'h0);
    bz  = (b[30:0] == 31'h0);
    if (asn || bsn || (ai && bz) || (az && bi)) return {4'b1000, 32'h7FC00000};
    if (an || bn) return {4'b0000, 32'h7FC00000};
    if (ai || bi) return {4'b0000, s, 8'hFF, 23'h0};
    if (az || bz) return {4'b0000, s, 31'h0};
    ma = {40'd0, a[30:23] != 8'h0, a[22:0]};
    mb = {40'd0, b[30:23] != 8'h0, b[22:0]};
    ea = (a[30:23] != 8'h0) ? int'(a[30:23]) - 127 : -126;
    eb = (b[30:23] != 8'h0) ? int'(b[30:23]) - 127 : -126;
    p  = ma * mb;
    e  = ea + eb - 46;
    msb = 0;
    for (int i = 0; i < 64; i++) if (p[i]) msb = i;
    qe = msb + e - 23;
    if (qe < -149) qe = -149;
    d = qe - e;
    tie = 1'b0; above = 1'b0; inexact = 1'b0;
    if (d <= 0) n = p << (-d);
    else if (d > 62) begin
      n = 0;
      inexact = 1'b1;
    end else begin
      n    = p >> d;
      rem  = p - (n << d);
      half = 64'd1 << (d - 1);
      inexact = (rem != 0);
      tie     = (rem == half);
      above   = (rem > half);
    end
    mode = (r > 3'd4) ? 3'd0 : r;
    case (mode)
      3'd0:    up = above || (tie && n[0]);
      3'd1:    up = 1'b0;
      3'd2:    up = s && inexact;
      3'd3:    up = !s && inexact;
      default: up = tie || above;
    endcase
    if (up) n = n + 1;
    if (n == (64'd1 << 24)) begin
      n  = n >> 1;
      qe = qe + 1;
    end
    if (n < (64'd1 << 23)) return {2'b00, inexact, inexact, s, 8'h00, n[22:0]};
    biased = qe + 150;
    if (biased >= 255) begin
      if (mode == 3'd1 || (mode == 3'd2 && !s) || (mode == 3'd3 && s))
        return {4'b0101, s, 8'hFE, 23'h7FFFFF};
      return {4'b0101, s, 8'hFF, 23'h0};
    end
    return {3'b000, inexact, s, 8'(biased), n[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 11))
      0:       v[30:23] = 8'h00;
      1:       v[30:0]  = 31'h0;
      2:       v[30:23] = 8'hFF;
      3:       v[30:0]  = {8'hFF, 23'h0};
      4, 5, 6, 7: v[30:23] = 8'($urandom_range(100, 154));
      default: ;
    endcase
    return v;
  endfunction

  task automatic push_exp(input logic [35:0] expv);
    exp_t t;
    t.acc_edge = cyc + 1;
    t.prod     = expv[31:0];
    t.flg      = expv[35:32];
    sb.push_back(t);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] r,
                      input logic [35:0] expv);
    int unsigned waited;
    waited = 0;
    while ((busy !== 1'b0 || valid_out !== 1'b0) && waited < 200) begin
      @(posedge clock); #1;
      waited++;
    end
    if (waited >= 200) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: got busy=%b valid_out=%b required both 0", busy, valid_out);
      return;
    end
    multiplicand = a; multiplier = b; rm = r; valid_in = 1'b1;
    push_exp(expv);
    @(posedge clock); #1;
    valid_in = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned waited;
    waited = 0;
    while ((busy !== 1'b0 || valid_out !== 1'b0) && waited < 200) begin
      @(posedge clock); #1;
      waited++;
    end
  endtask

  int   k;
  logic exp_busy;
  exp_t e_pop;

  always @(negedge clock) begin
    if (run) begin
      if (sb.size() != 0) begin
        k = cyc + 1 - sb[0].acc_edge;
        exp_busy = (k >= 1) && (k <= 26);
      end else begin
        exp_busy = 1'b0;
      end
      if (busy !== exp_busy) busy_err++;
      if (valid_out === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL spurious_valid_out: got 1 required 0 (product %h)", product);
        end else begin
          e_pop = sb.pop_front();
          chk("product", product, e_pop.prod);
          chk("flags_nv_of_uf_nx", {28'd0, nv, of, uf, nx}, {28'd0, e_pop.flg});
          chk("latency", 32'(cyc + 1 - e_pop.acc_edge), 32'd27);
          chk("busy_window", 32'(busy_err), 32'd0);
          busy_err = 0;
        end
      end
    end
  end

  initial begin
    logic [31:0] a, b;
    logic [2:0]  r;
    int          accepts;
    int unsigned waited;

    reset = 1'b0; valid_in = 1'b0; rm = 3'd0; multiplicand = '0; multiplier = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_product", product, 32'h0);
    chk("reset_flags", {28'd0, nv, of, uf, nx}, 32'h0);
    chk("reset_busy", {31'd0, busy}, 32'h0);
    chk("reset_valid_out", {31'd0, valid_out}, 32'h0);
    reset = 1'b1;
    run = 1'b1;
    @(posedge clock); #1;

    // Directed cases: expected {nv,of,uf,nx,product} written out by hand.
    send(32'h3FC00000, 32'h40000000, 3'd0, {4'b0000, 32'h40400000});
    send(32'h7F800000, 32'h00000000, 3'd0, {4'b1000, 32'h7FC00000});
    send(32'h7F800001, 32'h3F800000, 3'd0, {4'b1000, 32'h7FC00000});
    send(32'h7FC00000, 32'h3F800000, 3'd0, {4'b0000, 32'h7FC00000});
    send(32'h7F7FFFFF, 32'h40000000, 3'd0, {4'b0101, 32'h7F800000});
    send(32'h7F7FFFFF, 32'h40000000, 3'd1, {4'b0101, 32'h7F7FFFFF});
    send(32'hFF7FFFFF, 32'h40000000, 3'd3, {4'b0101, 32'hFF7FFFFF});
    send(32'hFF7FFFFF, 32'h40000000, 3'd2, {4'b0101, 32'hFF800000});
    send(32'h00800000, 32'h3F000000, 3'd0, {4'b0000, 32'h00400000});
    send(32'h00000001, 32'h3F000000, 3'd0, {4'b0011, 32'h00000000});
    send(32'h00000001, 32'h3F000000, 3'd3, {4'b0011, 32'h00000001});
    send(32'h00000001, 32'h3F000000, 3'd4, {4'b0011, 32'h00000001});
    send(32'h00000001, 32'h3F000000, 3'd7, {4'b0011, 32'h00000000});
    send(32'h80000001, 32'h3F000000, 3'd2, {4'b0011, 32'h80000001});
    send(32'h80000000, 32'h00000005, 3'd0, {4'b0000, 32'h80000000});
    send(32'hFF800000, 32'h7F800000, 3'd0, {4'b0000, 32'hFF800000});

    // Back-to-back: valid_in never drops; only idle-cycle operands are accepted.
    wait_idle();
    accepts = 0;
    for (int c = 0; c < 28 * 5 + 3; c++) begin
      a = rand_op(); b = rand_op(); r = 3'($urandom_range(0, 7));
      multiplicand = a; multiplier = b; rm = r; valid_in = 1'b1;
      if (busy === 1'b0 && valid_out === 1'b0) begin
        push_exp(ref_mul(a, b, r));
        accepts++;
      end
      @(posedge clock); #1;
    end
    valid_in = 1'b0;
    chk("b2b_accepts", 32'(accepts), 32'd6);

    // Reset during an operation aborts it.
    wait_idle();
    send(32'h3FC00000, 32'h40000000, 3'd0, {4'b0000, 32'h40400000});
    repeat (9) begin @(posedge clock); #1; end
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    sb.delete();
    busy_err = 0;
    chk("abort_busy", {31'd0, busy}, 32'h0);
    chk("abort_valid_out", {31'd0, valid_out}, 32'h0);
    chk("abort_product", product, 32'h0);
    repeat (40) begin @(posedge clock); #1; end
    send(32'h40400000, 32'h40400000, 3'd0, {4'b0000, 32'h41100000});

    for (int t = 0; t < 120; t++) begin
      a = rand_op(); b = rand_op(); r = 3'($urandom_range(0, 7));
      send(a, b, r, ref_mul(a, b, r));
      repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
    end

    waited = 0;
    while (sb.size() != 0 && waited < 100) begin
      @(posedge clock); #1;
      waited++;
    end
    while (sb.size() != 0) begin
      e_pop = sb.pop_front();
      n_cmp++; n_bad++;
      $display("FAIL missing_result: got no valid_out required product %h", e_pop.prod);
    end
    repeat (3) @(posedge clock);
    #1;
    chk("busy_idle", 32'(busy_err), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
